// File: rtl/ysyx_23060208_rd_arbiter_pkg.sv
// Shared definitions for the IFU/LSU read-channel arbiter in front of the CLINT.
package ysyx_23060208_rd_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    DATA = 2'b10
  } state_e;

  localparam logic M_IFU = 1'b0;
  localparam logic M_LSU = 1'b1;
endpackage

// File: rtl/ysyx_23060208_arb_pick.sv
// Combinational winner selection: a tie goes to the master that was not granted last.
module ysyx_23060208_arb_pick
  import ysyx_23060208_rd_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);
  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) gnt_o = (last_i == M_LSU) ? 2'b01 : 2'b10;
  end
endmodule

// File: rtl/ysyx_23060208_rd_arbiter.sv
// Two-master (IFU=m0, LSU=m1) AXI read arbiter, one outstanding transaction.
// YSYX_23060208_ARB_RR_EN selects round-robin ties; otherwise LSU has fixed priority.
module ysyx_23060208_rd_arbiter
  import ysyx_23060208_rd_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   m0_araddr,
  input  logic                    m0_arvalid,
  output logic                    m0_arready,
  input  logic [3:0]              m0_arid,
  input  logic [7:0]              m0_arlen,
  input  logic [2:0]              m0_arsize,
  input  logic [1:0]              m0_arburst,
  output logic                    m0_rvalid,
  output logic [2*DATA_WIDTH-1:0] m0_rdata,
  output logic [1:0]              m0_rresp,
  output logic                    m0_rlast,
  output logic [3:0]              m0_rid,
  input  logic                    m0_rready,
  input  logic [DATA_WIDTH-1:0]   m1_araddr,
  input  logic                    m1_arvalid,
  output logic                    m1_arready,
  input  logic [3:0]              m1_arid,
  input  logic [7:0]              m1_arlen,
  input  logic [2:0]              m1_arsize,
  input  logic [1:0]              m1_arburst,
  output logic                    m1_rvalid,
  output logic [2*DATA_WIDTH-1:0] m1_rdata,
  output logic [1:0]              m1_rresp,
  output logic                    m1_rlast,
  output logic [3:0]              m1_rid,
  input  logic                    m1_rready,
  output logic [DATA_WIDTH-1:0]   s_araddr,
  output logic                    s_arvalid,
  input  logic                    s_arready,
  output logic [3:0]              s_arid,
  output logic [7:0]              s_arlen,
  output logic [2:0]              s_arsize,
  output logic [1:0]              s_arburst,
  input  logic                    s_rvalid,
  input  logic [2*DATA_WIDTH-1:0] s_rdata,
  input  logic [1:0]              s_rresp,
  input  logic                    s_rlast,
  input  logic [3:0]              s_rid,
  output logic                    s_rready
);
  localparam int RW = 2*DATA_WIDTH;

  state_e state_q, state_d;
  logic   owner_q, owner_d;
  logic [1:0][15:0] cnt_q, cnt_d;

  logic [1:0] req, gnt, arvalid, rready;
  logic [1:0][DATA_WIDTH-1:0] araddr;
  logic [1:0][3:0] arid;
  logic [1:0][7:0] arlen;
  logic [1:0][2:0] arsize;
  logic [1:0][1:0] arburst;
  logic [1:0] arready, rvalid, rlast;
  logic [1:0][RW-1:0] rdata;
  logic [1:0][1:0] rresp;
  logic [1:0][3:0] rid;
  logic last_ptr;

  assign arvalid = {m1_arvalid, m0_arvalid};
  assign req     = arvalid;
  assign rready  = {m1_rready, m0_rready};
  assign araddr  = {m1_araddr, m0_araddr};
  assign arid    = {m1_arid, m0_arid};
  assign arlen   = {m1_arlen, m0_arlen};
  assign arsize  = {m1_arsize, m0_arsize};
  assign arburst = {m1_arburst, m0_arburst};

  ysyx_23060208_arb_pick u_pick (
    .req_i  (req),
    .last_i (last_ptr),
    .gnt_o  (gnt)
  );

`ifdef YSYX_23060208_ARB_RR_EN
  logic last_q;
  always_ff @(posedge clock or negedge reset)
    if (!reset) last_q <= M_LSU;
    else if (state_q == IDLE && |gnt) last_q <= gnt[1];
  assign last_ptr = last_q;
`else
  // Pretending IFU was granted last makes every tie resolve to LSU.
  assign last_ptr = M_IFU;
`endif

  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= M_IFU;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    s_araddr  = '0;
    s_arvalid = 1'b0;
    s_arid    = '0;
    s_arlen   = '0;
    s_arsize  = '0;
    s_arburst = '0;
    s_rready  = 1'b0;
    arready   = '0;
    rvalid    = '0;
    rdata     = '0;
    rresp     = '0;
    rlast     = '0;
    rid       = '0;
    case (state_q)
      IDLE: if (|gnt) begin
        owner_d = gnt[1];
        state_d = ADDR;
      end
      ADDR: begin
        s_araddr         = araddr[owner_q];
        s_arvalid        = arvalid[owner_q];
        s_arid           = arid[owner_q];
        s_arlen          = arlen[owner_q];
        s_arsize         = arsize[owner_q];
        s_arburst        = arburst[owner_q];
        arready[owner_q] = s_arready;
        if (s_arvalid && s_arready) state_d = DATA;
      end
      DATA: begin
        s_rready       = rready[owner_q];
        rvalid[owner_q] = s_rvalid;
        rdata[owner_q]  = s_rdata;
        rresp[owner_q]  = s_rresp;
        rlast[owner_q]  = s_rlast;
        rid[owner_q]    = s_rid;
        if (s_rvalid && s_rready && s_rlast) begin
          state_d = IDLE;
          if (cnt_q[owner_q] != 16'hFFFF) cnt_d[owner_q] = cnt_q[owner_q] + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign m0_arready = arready[0];
  assign m0_rvalid  = rvalid[0];
  assign m0_rdata   = rdata[0];
  assign m0_rresp   = rresp[0];
  assign m0_rlast   = rlast[0];
  assign m0_rid     = rid[0];
  assign m1_arready = arready[1];
  assign m1_rvalid  = rvalid[1];
  assign m1_rdata   = rdata[1];
  assign m1_rresp   = rresp[1];
  assign m1_rlast   = rlast[1];
  assign m1_rid     = rid[1];
endmodule

// File: tb/tb_ysyx_23060208_rd_arbiter.sv
// Scoreboard bench for the IFU/LSU read arbiter with a randomized CLINT-like slave.
module tb_ysyx_23060208_rd_arbiter;
  localparam int DW = 32;
  localparam int RW = 64;
`ifdef YSYX_23060208_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    int          m;
    logic [31:0] addr;
    logic [3:0]  id;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ar_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [1:0] m_arvalid, m_rready;
  logic [1:0][31:0] m_araddr;
  logic [1:0][3:0] m_arid;
  logic [1:0][7:0] m_arlen;
  logic [1:0][2:0] m_arsize;
  logic [1:0][1:0] m_arburst;
  wire  [1:0] m_arready, m_rvalid, m_rlast;
  wire  [1:0][RW-1:0] m_rdata;
  wire  [1:0][1:0] m_rresp;
  wire  [1:0][3:0] m_rid;

  wire  [31:0] s_araddr;
  wire  s_arvalid, s_rready;
  wire  [3:0] s_arid;
  wire  [7:0] s_arlen;
  wire  [2:0] s_arsize;
  wire  [1:0] s_arburst;
  logic s_arready, s_rvalid, s_rlast;
  logic [RW-1:0] s_rdata;
  logic [1:0] s_rresp;
  logic [3:0] s_rid;

  ysyx_23060208_rd_arbiter #(.DATA_WIDTH(DW)) dut (
    .clock(clock), .reset(reset),
    .m0_araddr(m_araddr[0]), .m0_arvalid(m_arvalid[0]), .m0_arready(m_arready[0]),
    .m0_arid(m_arid[0]), .m0_arlen(m_arlen[0]), .m0_arsize(m_arsize[0]), .m0_arburst(m_arburst[0]),
    .m0_rvalid(m_rvalid[0]), .m0_rdata(m_rdata[0]), .m0_rresp(m_rresp[0]), .m0_rlast(m_rlast[0]),
    .m0_rid(m_rid[0]), .m0_rready(m_rready[0]),
    .m1_araddr(m_araddr[1]), .m1_arvalid(m_arvalid[1]), .m1_arready(m_arready[1]),
    .m1_arid(m_arid[1]), .m1_arlen(m_arlen[1]), .m1_arsize(m_arsize[1]), .m1_arburst(m_arburst[1]),
    .m1_rvalid(m_rvalid[1]), .m1_rdata(m_rdata[1]), .m1_rresp(m_rresp[1]), .m1_rlast(m_rlast[1]),
    .m1_rid(m_rid[1]), .m1_rready(m_rready[1]),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rid(s_rid), .s_rready(s_rready)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [RW-1:0] rd_f(input logic [31:0] a, input int b);
    return {a ^ 32'hA5A5_5A5A, a + 32'(b)};
  endfunction

  function automatic logic [1:0] resp_f(input logic [3:0] id, input int b);
    return id[1:0] ^ 2'(b);
  endfunction

  // Slave: random arready, random rvalid gaps (held until accepted), garbage when idle.
  logic sl_busy, af, rf;
  logic [31:0] sa;
  logic [3:0] si;
  logic [7:0] sl, sb;
  initial begin
    s_arready = 0; s_rvalid = 0; s_rdata = '0; s_rresp = 0; s_rlast = 0; s_rid = 0;
    sl_busy = 0; sa = 0; si = 0; sl = 0; sb = 0;
    forever begin
      @(negedge clock);
      af = s_arvalid & s_arready;
      rf = s_rvalid & s_rready;
      if (af) begin sa = s_araddr; si = s_arid; sl = s_arlen; end
      @(posedge clock); #1;
      if (!reset) sl_busy = 0;
      else if (af) begin sl_busy = 1; sb = 0; end
      else if (rf) begin
        if (sb == sl) sl_busy = 0;
        else sb = sb + 8'd1;
      end
      s_arready = !sl_busy && ($urandom_range(0, 2) != 0);
      if (!(sl_busy && s_rvalid && !rf)) s_rvalid = sl_busy && ($urandom_range(0, 3) != 0);
      s_rdata = sl_busy ? rd_f(sa, int'(sb)) : {$urandom, $urandom};
      s_rlast = sl_busy ? (sb == sl) : 1'($urandom_range(0, 1));
      s_rid   = si;
      s_rresp = resp_f(si, int'(sb));
    end
  end

  // Monitor / scoreboard.
  ar_t expq[$];
  ar_t e;
  logic [1:0] outst;
  logic [1:0][31:0] c_addr;
  logic [1:0][3:0] c_id;
  logic [1:0][7:0] c_len;
  int beat [2];
  int done_cnt = 0;
  bit prev_last, lf, xl;
  initial begin
    outst = 0; prev_last = 0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        expq.delete(); outst = 0; prev_last = 0;
      end else begin
        lf = 0;
        for (int i = 0; i < 2; i++)
          if (m_arready[i]) chk("arready_owner", i, (expq.size() != 0) ? expq[0].m : -1);
        if (prev_last) chk("idle_bubble", s_arvalid, 0);
        if (s_arvalid && s_arready) begin
          if (expq.size() == 0) chk("ar_unexpected", 1, 0);
          else begin
            e = expq.pop_front();
            chk("ar_master", m_arready[1] ? 1 : 0, e.m);
            chk("ar_addr", s_araddr, e.addr);
            chk("ar_id", s_arid, e.id);
            chk("ar_len", s_arlen, e.len);
            chk("ar_size", s_arsize, e.size);
            chk("ar_burst", s_arburst, e.burst);
            outst[e.m] = 1; c_addr[e.m] = e.addr; c_id[e.m] = e.id; c_len[e.m] = e.len; beat[e.m] = 0;
          end
        end
        for (int i = 0; i < 2; i++) begin
          if (outst[1-i]) begin
            chk("nonowner_rvalid", m_rvalid[i], 0);
            chk("nonowner_rdata", m_rdata[i], 0);
            chk("nonowner_rmisc", {m_rlast[i], m_rresp[i], m_rid[i]}, 0);
          end
          if (m_rvalid[i] && !outst[i]) chk("rvalid_stray", i, 9);
          if (outst[i] && s_rvalid) chk("s_rready", s_rready, m_rready[i]);
          if (outst[i] && m_rvalid[i] && m_rready[i]) begin
            xl = (beat[i] == int'(c_len[i]));
            chk("r_data", m_rdata[i], rd_f(c_addr[i], beat[i]));
            chk("r_id", m_rid[i], c_id[i]);
            chk("r_resp", m_rresp[i], resp_f(c_id[i], beat[i]));
            chk("r_last", m_rlast[i], xl);
            if (xl) begin outst[i] = 0; done_cnt++; lf = 1; end
            else beat[i]++;
          end
        end
        prev_last = lf;
      end
    end
  end

  // Stimulus and arbitration model.
  int last_g = 1;
  int lat_n = 0;
  logic [31:0] lat_addr;
  logic [1:0] hold, smp_rv;

  task automatic tick();
    logic [1:0] f;
    @(negedge clock);
    f = m_arvalid & m_arready;
    smp_rv = m_rvalid;
    if (lat_n == 2) chk("ar_before_grant", s_arvalid, 0);
    else if (lat_n == 1) begin
      chk("grant_to_ar", s_arvalid, 1);
      chk("grant_addr", s_araddr, lat_addr);
    end
    if (lat_n > 0) lat_n--;
    @(posedge clock); #1;
    for (int i = 0; i < 2; i++) begin
      if (f[i]) m_arvalid[i] = 1'b0;
      m_rready[i] = hold[i] ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  endtask

  // Winner order comes straight from the arbitration rules: a tie goes to LSU
  // under fixed priority, or to the master not granted last under round-robin.
  task automatic issue(input logic [1:0] mask, input int lmax, input logic [31:0] a0, input logic [31:0] a1);
    ar_t r [2];
    int first;
    for (int i = 0; i < 2; i++) begin
      r[i].m = i;
      r[i].addr = (i == 0) ? a0 : a1;
      r[i].id = 4'($urandom_range(0, 15));
      r[i].len = 8'($urandom_range(0, lmax));
      r[i].size = 3'($urandom_range(0, 7));
      r[i].burst = 2'($urandom_range(0, 3));
    end
    if (mask == 2'b11) first = RR ? (1 - last_g) : 1;
    else first = mask[1] ? 1 : 0;
    expq.push_back(r[first]);
    if (mask == 2'b11) expq.push_back(r[1-first]);
    last_g = (mask == 2'b11) ? 1 - first : first;
    for (int i = 0; i < 2; i++)
      if (mask[i]) begin
        m_arvalid[i] = 1; m_araddr[i] = r[i].addr; m_arid[i] = r[i].id;
        m_arlen[i] = r[i].len; m_arsize[i] = r[i].size; m_arburst[i] = r[i].burst;
      end
    lat_n = 2;
    lat_addr = r[first].addr;
  endtask

  task automatic wait_done(input int target);
    for (int c = 0; c < 2000 && done_cnt < target; c++) tick();
    chk("txn_complete", done_cnt >= target, 1);
  endtask

  task automatic round(input logic [1:0] mask, input int lmax);
    int t;
    t = done_cnt + int'(mask[0]) + int'(mask[1]);
    issue(mask, lmax, $urandom, $urandom);
    wait_done(t);
    tick(); tick();
  endtask

  task automatic wait_rvalid0(output bit seen);
    seen = 0;
    for (int c = 0; c < 200 && !seen; c++) begin tick(); seen = smp_rv[0]; end
    chk("rvalid_seen", seen, 1);
  endtask

  initial begin
    int t;
    bit seen;
    logic [RW-1:0] snap;
    m_arvalid = 0; m_rready = 0; m_araddr = '0; m_arid = '0; m_arlen = '0;
    m_arsize = '0; m_arburst = '0; hold = 0; smp_rv = 0; lat_addr = 0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_s_arvalid", s_arvalid, 0);
    chk("rst_s_rready", s_rready, 0);
    chk("rst_arready", m_arready, 0);
    chk("rst_rvalid", m_rvalid, 0);
    chk("rst_rdata0", m_rdata[0], 0);
    chk("rst_s_araddr", s_araddr, 0);
    @(posedge clock); #1;
    reset = 1;
    tick();

    // First tie after reset, then a lone IFU fetch from mtime.
    t = done_cnt + 2; issue(2'b11, 3, 32'h0200_BFF8, $urandom); wait_done(t); tick(); tick();
    t = done_cnt + 1; issue(2'b01, 0, 32'h0200_BFF8, 0); wait_done(t); tick(); tick();
    repeat (4) round(2'b11, 2);

    // Owner holds rready low while the slave presents data.
    hold = 2'b01;
    t = done_cnt + 1;
    issue(2'b01, 0, $urandom, 0);
    wait_rvalid0(seen);
    @(negedge clock);
    snap = m_rdata[0];
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("bp_s_rready", s_rready, 0);
      chk("bp_rvalid", m_rvalid[0], 1);
      chk("bp_rdata", m_rdata[0], snap);
    end
    hold = 0;
    wait_done(t); tick(); tick();

    for (int r = 0; r < 40; r++) round(2'($urandom_range(1, 3)), 3);

    // Reset pulse in the middle of a DATA phase.
    hold = 2'b01;
    issue(2'b01, 3, $urandom, 0);
    wait_rvalid0(seen);
    #2 reset = 0;
    #1;
    chk("mid_rst_rvalid", m_rvalid, 0);
    chk("mid_rst_rdata0", m_rdata[0], 0);
    chk("mid_rst_s_rready", s_rready, 0);
    chk("mid_rst_s_arvalid", s_arvalid, 0);
    chk("mid_rst_arready", m_arready, 0);
    m_arvalid = 0; hold = 0; last_g = 1;
    repeat (3) tick();
    reset = 1;
    @(negedge clock);
    chk("post_rst_no_ar", s_arvalid, 0);
    @(posedge clock); #1;
    round(2'b10, 3);
    round(2'b11, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ysyx_23060208_rd_arbiter.md
YSYX_23060208_RD_ARBITER -- requirements
Module: ysyx_23060208_rd_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the address width; read data width SHALL be DATA_WIDTH*2.
REQ-002 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; all state SHALL clear immediately when reset is 0.
REQ-004 araddr  m0_/m1_ input, s_ output  DATA_WIDTH  read address; m0 is IFU, m1 is LSU, s is the shared slave (CLINT).
REQ-005 arvalid  m0_/m1_ input, s_ output  1  read address valid.
REQ-006 arready  m0_/m1_ output, s_ input  1  read address ready.
REQ-007 arid  m0_/m1_ input, s_ output  4  transaction id.
REQ-008 arlen  m0_/m1_ input, s_ output  8  burst length minus 1.
REQ-009 arsize  m0_/m1_ input, s_ output  3  beat size.
REQ-010 arburst  m0_/m1_ input, s_ output  2  burst type.
REQ-011 rvalid  m0_/m1_ output, s_ input  1  read data valid.
REQ-012 rdata  m0_/m1_ output, s_ input  DATA_WIDTH*2  read data.
REQ-013 rresp  m0_/m1_ output, s_ input  2  read response.
REQ-014 rlast  m0_/m1_ output, s_ input  1  last beat.
REQ-015 rid  m0_/m1_ output, s_ input  4  response id.
REQ-016 rready  m0_/m1_ input, s_ output  1  read data ready.

Function
REQ-017 The FSM SHALL have three states: IDLE, ADDR, DATA; one transaction SHALL be outstanding at a time.
REQ-018 IDLE: if any m*_arvalid=1, the winner SHALL be latched into register owner and the FSM SHALL move to ADDR on the next edge; otherwise it stays in IDLE.
REQ-019 IDLE: all arready and rvalid outputs SHALL be 0 and s_arvalid/s_rready SHALL be 0.
REQ-020 ADDR: s_ar* SHALL equal owner's ar* combinationally; owner arready SHALL equal s_arready; non-owner arready SHALL be 0.
REQ-021 ADDR: on s_arvalid&s_arready the FSM SHALL move to DATA; if owner drops arvalid, the FSM SHALL stay in ADDR.
REQ-022 DATA: s_rready SHALL equal owner rready; owner r* SHALL equal s_r*; non-owner rvalid SHALL be 0 and its rdata/rresp/rlast/rid SHALL be 0.
REQ-023 DATA: on s_rvalid&s_rready&s_rlast the FSM SHALL return to IDLE; non-last beats SHALL keep it in DATA.
REQ-024 Grant-to-AR latency SHALL be one cycle; back-to-back transactions SHALL have one IDLE bubble.
REQ-025 A 16-bit saturating counter per master, m0_cnt and m1_cnt, SHALL increment on each completed last beat; it is internal, for debug only.
REQ-026 A request that arrives while the FSM is in ADDR or DATA SHALL be held, not dropped, and arbitrated on the next IDLE.

Reset
REQ-027 Reset SHALL set the FSM to IDLE, owner to m0, last-grant pointer to m1, counters to 0, and all outputs low.
REQ-028 Reset asserted mid-transaction SHALL abort it without completing; after reset releases, the first AR SHALL occur only after a new IDLE arbitration.

Configuration
REQ-029 With macro YSYX_23060208_ARB_RR_EN defined, simultaneous requests SHALL be granted to the master other than the last-granted one, and the pointer SHALL update at each grant.
REQ-030 Without YSYX_23060208_ARB_RR_EN, fixed priority SHALL apply (m1/LSU over m0/IFU), and the pointer SHALL be absent.

Structure
REQ-031 The shared package SHALL hold the FSM state encoding (IDLE=2'b00, ADDR=2'b01, DATA=2'b10) and the master index constants M_IFU=0, M_LSU=1.
REQ-032 One sub-module, ysyx_23060208_arb_pick, SHALL implement the combinational winner selection (two requests plus pointer in, one-hot grant out).

Verification
REQ-033 Only m0 requests araddr=0x0200_BFF8 -> s_araddr=0x0200_BFF8 in the cycle after the request; m0 receives the 64-bit rdata; m1_rvalid stays 0.
REQ-034 m0 and m1 request in the same cycle with RR enabled after reset -> m0 is granted first, then m1 after m0's rlast plus one IDLE cycle.
REQ-035 Same stimulus as REQ-034 with RR disabled -> m1 is granted first, and m1 wins every tie over 4 repeated ties.
REQ-036 s_rvalid=1 with owner rready=0 for 5 cycles -> the FSM stays in DATA, s_rready=0, and the data is held until rready=1.
REQ-037 reset=0 pulsed during DATA -> all outputs go 0 immediately and the FSM is IDLE; a new m1 request afterwards completes normally.
REQ-038 m1 asserts arvalid while m0 owns DATA -> m1_arready stays 0 until m0's transaction completes, then m1 is granted.
